// File: rtl/loader_pkg.sv
// Shared definitions for the instruction RAM loader: FSM state encoding and word width.
package loader_pkg;

    // Width of one instruction / stream word.
    localparam int unsigned INSTR_W = 16;

    // Loader FSM states; encodings are fixed so they can be matched in traces.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        LEN     = 3'd2,
        DATA    = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_e;

    // States in which the loader accepts stream words.
    function automatic logic state_accepts(input state_e s);
        return (s == HDR) || (s == LEN) || (s == DATA);
    endfunction

endpackage

// File: rtl/instr_ram8_loader_if.sv
// Loader bus: host stream in, instruction RAM write port and core control out.
interface instr_ram8_loader_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned AW        = 16
);
    import loader_pkg::*;

    // Host side.
    logic                    load_start;
    logic                    in_valid;
    logic [INSTR_W-1:0]      in_data;
    logic                    in_ready;

    // Instruction RAM write port.
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [INSTR_W-1:0]      mem_wdata;

    // Core control and status.
    logic                    core_hold;
    logic [NUM_PORTS*AW-1:0] start_addr;
    logic                    busy;
    logic                    done;
    logic                    error;

    // Host / observer side: issues the stream, watches RAM writes and status.
    modport master (
        output load_start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  core_hold, start_addr, busy, done, error
    );

    // Loader side.
    modport slave (
        input  load_start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output core_hold, start_addr, busy, done, error
    );

endinterface

// File: rtl/loader_wr_stage.sv
// One-cycle register stage between the loader FSM and the instruction RAM write port.
module loader_wr_stage
    import loader_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [INSTR_W-1:0] i_wdata,
    output logic               o_we,
    output logic [AW-1:0]      o_addr,
    output logic [INSTR_W-1:0] o_wdata
);

    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [INSTR_W-1:0] r_wdata;

    // Register the write strobe, address and data; reset clears the port to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/instr_ram8_loader.sv
// Instruction RAM loader: takes a header (per-core start addresses, then image length)
// followed by the program image, writes the image into RAM and releases the cores.
module instr_ram8_loader
    import loader_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AW        = 16
) (
    input  logic               clk,
    input  logic               reset,
    instr_ram8_loader_if.slave bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = $clog2(DEPTH + 1);
    localparam int unsigned HW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [INSTR_W-1:0] DEPTH_W   = INSTR_W'(DEPTH);
    localparam logic [HW-1:0]      HDR_LAST  = HW'(NUM_PORTS - 1);

    // State and counters.
    state_e                          r_state;
    state_e                          w_state_nxt;
    logic [HW-1:0]                   r_hdr_cnt;
    logic [HW-1:0]                   w_hdr_cnt_nxt;
    logic [PW-1:0]                   r_wr_ptr;
    logic [PW-1:0]                   w_wr_ptr_nxt;
    logic [RW-1:0]                   r_remain;
    logic [RW-1:0]                   w_remain_nxt;
    logic [RW-1:0]                   r_len;
    logic [RW-1:0]                   w_len_nxt;
    logic [NUM_PORTS-1:0][AW-1:0]    r_start_addr;
    logic [NUM_PORTS-1:0][AW-1:0]    w_start_addr_nxt;

    // Handshake and decode.
    logic                            w_in_ready;
    logic                            w_accept;
    logic                            w_len_ok;
    logic                            w_addr_bad;

    // Unregistered write request fed to the write stage.
    logic                            w_we;
    logic [AW-1:0]                   w_addr;

    assign w_in_ready = state_accepts(r_state);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_len_ok   = (bus.in_data != '0) && (bus.in_data <= DEPTH_W);
    assign w_addr     = AW'(r_wr_ptr);

    // Flag any start address that would point past the loaded image.
    always_comb begin
        w_addr_bad = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_start_addr[k] >= AW'(r_len)) begin
                w_addr_bad = 1'b1;
            end
        end
    end

    // Next-state logic for the FSM, counters and start-address registers.
    always_comb begin
        w_state_nxt      = r_state;
        w_hdr_cnt_nxt    = r_hdr_cnt;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_remain_nxt     = r_remain;
        w_len_nxt        = r_len;
        w_start_addr_nxt = r_start_addr;
        w_we             = 1'b0;

        unique case (r_state)
            IDLE, DONE, ERR: begin
                if (bus.load_start) begin
                    w_state_nxt   = HDR;
                    w_hdr_cnt_nxt = '0;
                end
            end
            HDR: begin
                if (w_accept) begin
                    w_start_addr_nxt[r_hdr_cnt] = AW'(bus.in_data);
                    w_hdr_cnt_nxt               = r_hdr_cnt + 1'b1;
                    if (r_hdr_cnt == HDR_LAST) begin
                        w_state_nxt = LEN;
                    end
                end
            end
            LEN: begin
                if (w_accept) begin
                    if (!w_len_ok) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_wr_ptr_nxt = '0;
                        w_remain_nxt = RW'(bus.in_data);
                        w_len_nxt    = RW'(bus.in_data);
                        w_state_nxt  = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_we = 1'b1;
                    if (r_remain == RW'(1)) begin
                        // Last word: pointer stays put so it never walks past DEPTH-1.
                        w_remain_nxt = '0;
                        w_state_nxt  = w_addr_bad ? ERR : RELEASE;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        w_remain_nxt = r_remain - 1'b1;
                    end
                end
            end
            RELEASE: begin
                // Lets the final RAM write land before the cores start fetching.
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; RAM contents are not touched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hdr_cnt    <= '0;
            r_wr_ptr     <= '0;
            r_remain     <= '0;
            r_len        <= '0;
            r_start_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hdr_cnt    <= w_hdr_cnt_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_remain     <= w_remain_nxt;
            r_len        <= w_len_nxt;
            r_start_addr <= w_start_addr_nxt;
        end
    end

    loader_wr_stage #(
        .AW (AW)
    ) u_wr_stage (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (bus.in_data),
        .o_we    (bus.mem_we),
        .o_addr  (bus.mem_addr),
        .o_wdata (bus.mem_wdata)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_in_ready;
    assign bus.done       = (r_state == DONE);
    assign bus.error      = (r_state == ERR);
    // Cores run only once the image is complete; every other state keeps them halted.
    assign bus.core_hold  = (r_state != DONE);
    assign bus.start_addr = r_start_addr;

endmodule

// File: tb/tb_instr_ram8_loader.sv
// Scoreboard bench for instr_ram8_loader: the driver queues expected RAM writes,
// a negedge monitor pops and compares them and keeps a shadow copy of the RAM.
module tb_instr_ram8_loader;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned AW        = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_ram8_loader_if #(.NUM_PORTS(NUM_PORTS), .AW(AW)) bus ();

    instr_ram8_loader #(
        .NUM_PORTS (NUM_PORTS),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          we_count = 0;
    int          wc;
    wr_t         exp_q[$];
    logic [15:0] ram [0:DEPTH-1];
    logic        drv_xfer  = 1'b0;
    logic        prev_xfer = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: a write must appear exactly one cycle after each data transfer and match the queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we || prev_xfer) begin
            check("mem_we_vs_xfer", 64'(bus.mem_we), 64'(prev_xfer));
        end
        if (bus.mem_we) begin
            we_count++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(e.data));
            end
            ram[bus.mem_addr[5:0]] = bus.mem_wdata;
        end
        prev_xfer = drv_xfer;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input bit is_data, input logic [15:0] addr);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        drv_xfer     = is_data;
        if (is_data) exp_q.push_back('{addr: addr, data: w});
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        drv_xfer     = 1'b0;
    endtask

    task automatic gap();
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
        drv_xfer     = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [15:0] a3);
        send(a0, 1'b0, 16'd0);
        send(a1, 1'b0, 16'd0);
        send(a2, 1'b0, 16'd0);
        send(a3, 1'b0, 16'd0);
    endtask

    task automatic send_image(input int n, input logic [15:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) gap();
            send(16'(base + 16'(i)), 1'b1, 16'(i));
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset values.
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_core_hold", 64'(bus.core_hold), 64'd1);
        check("rst_start_addr", bus.start_addr, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);
        reset = 1'b0;
        tick();

        // Test 1: nominal load.
        wc = we_count;
        pulse_start();
        check("t1_busy", 64'(bus.busy), 64'd1);
        send_hdr(16'd0, 16'd3, 16'd6, 16'd9);
        send(16'd12, 1'b0, 16'd0);
        send_image(12, 16'hA000, 1'b0);
        check("t1_release_hold", 64'(bus.core_hold), 64'd1);
        check("t1_release_done", 64'(bus.done), 64'd0);
        check("t1_release_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("t1_core_hold", 64'(bus.core_hold), 64'd0);
        check("t1_done", 64'(bus.done), 64'd1);
        check("t1_error", 64'(bus.error), 64'd0);
        check("t1_start_addr", bus.start_addr, 64'h0009_0006_0003_0000);
        check("t1_writes", 64'(we_count - wc), 64'd12);
        check("t1_queue", 64'(exp_q.size()), 64'd0);

        // Test 6: re-load from DONE with a shorter image.
        wc = we_count;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("t6_core_hold", 64'(bus.core_hold), 64'd1);
        check("t6_done", 64'(bus.done), 64'd0);
        send_hdr(16'd0, 16'd1, 16'd2, 16'd3);
        send(16'd4, 1'b0, 16'd0);
        send_image(4, 16'hB000, 1'b0);
        tick();
        check("t6_done_again", 64'(bus.done), 64'd1);
        check("t6_writes", 64'(we_count - wc), 64'd4);
        for (int i = 0; i < 4; i++) check("t6_ram_new", 64'(ram[i]), 64'(16'hB000 + 16'(i)));
        for (int i = 4; i < 12; i++) check("t6_ram_old", 64'(ram[i]), 64'(16'hA000 + 16'(i)));

        // Test 4: back-pressure gaps during DATA.
        wc = we_count;
        pulse_start();
        send_hdr(16'd0, 16'd3, 16'd6, 16'd9);
        send(16'd12, 1'b0, 16'd0);
        send_image(12, 16'hA000, 1'b1);
        tick();
        check("t4_done", 64'(bus.done), 64'd1);
        check("t4_writes", 64'(we_count - wc), 64'd12);
        for (int i = 0; i < 12; i++) check("t4_ram", 64'(ram[i]), 64'(16'hA000 + 16'(i)));

        // Test 2: bad length 0, then 65.
        wc = we_count;
        pulse_start();
        check("t2_done_clr", 64'(bus.done), 64'd0);
        send_hdr(16'd1, 16'd2, 16'd3, 16'd4);
        send(16'd0, 1'b0, 16'd0);
        check("t2_error", 64'(bus.error), 64'd1);
        check("t2_core_hold", 64'(bus.core_hold), 64'd1);
        check("t2_in_ready", 64'(bus.in_ready), 64'd0);
        check("t2_start_addr", bus.start_addr, 64'h0004_0003_0002_0001);
        tick();
        check("t2_error_hold", 64'(bus.error), 64'd1);
        pulse_start();
        check("t2_error_clr", 64'(bus.error), 64'd0);
        send_hdr(16'd5, 16'd6, 16'd7, 16'd8);
        send(16'd65, 1'b0, 16'd0);
        check("t2_error65", 64'(bus.error), 64'd1);
        check("t2_core_hold65", 64'(bus.core_hold), 64'd1);
        tick();
        check("t2_writes", 64'(we_count - wc), 64'd0);

        // Test 3: start address beyond the image.
        wc = we_count;
        pulse_start();
        send_hdr(16'd0, 16'd3, 16'd6, 16'd20);
        send(16'd12, 1'b0, 16'd0);
        send_image(12, 16'hC000, 1'b0);
        check("t3_error", 64'(bus.error), 64'd1);
        check("t3_done", 64'(bus.done), 64'd0);
        tick();
        check("t3_core_hold", 64'(bus.core_hold), 64'd1);
        check("t3_writes", 64'(we_count - wc), 64'd12);
        check("t3_start_addr", bus.start_addr, 64'h0014_0006_0003_0000);

        // Test 5: reset after five data words.
        wc = we_count;
        pulse_start();
        send_hdr(16'd0, 16'd1, 16'd2, 16'd3);
        send(16'd12, 1'b0, 16'd0);
        send_image(5, 16'hD000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_in_ready", 64'(bus.in_ready), 64'd0);
        check("t5_start_addr", bus.start_addr, 64'd0);
        check("t5_core_hold", 64'(bus.core_hold), 64'd1);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_mem_we", 64'(bus.mem_we), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hEEEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_idle_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        tick();
        check("t5_writes", 64'(we_count - wc), 64'd5);
        check("t5_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
